// File: rtl/ram_bist_rw_if.sv
// rtl/ram_bist_rw_if.sv - control/result bundle between a test controller and ram_bist_rw
interface ram_bist_rw_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
);
   logic              start;
   logic              mode;
   logic [DATA_W-1:0] seed;
   logic              inject_err;
   logic              busy;
   logic              done;
   logic              pass;
   logic [ADDR_W:0]   err_cnt;
   logic [ADDR_W-1:0] first_err_addr;
   logic [DATA_W-1:0] rd_data;

   modport master (
      output start, mode, seed, inject_err,
      input  busy, done, pass, err_cnt, first_err_addr, rd_data
   );

   modport slave (
      input  start, mode, seed, inject_err,
      output busy, done, pass, err_cnt, first_err_addr, rd_data
   );
endinterface

// File: rtl/ram_bist_rw.sv
// rtl/ram_bist_rw.sv - write/read-back self-test over an inferred single-port RAM
// Optional macro RAM_OUT_REG_EN adds an output register after the RAM read port.
module ram_bist_rw #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32
) (
   input logic         sys_clk,
   input logic         sys_rst_n,
   ram_bist_rw_if.slave bus
);

`ifdef RAM_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] cnt;
   logic              busy, done, wr_en, rd_en, accept;
   logic              last_addr, last_drain;
   logic              mode_q, inj_q;
   logic [DATA_W-1:0] seed_q;
   logic [DATA_W-1:0] exp_cur, wdata;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] ram_q, rd_data;
   logic [LAT-1:0]    vld_p;
   logic [DATA_W-1:0] exp_p [LAT];
   logic [ADDR_W-1:0] adr_p [LAT];
   logic              mismatch;
   logic [ADDR_W:0]   err_cnt;
   logic [ADDR_W-1:0] first_err;
   logic              pass_q;

   // Address is zero-extended (or truncated) to the word width before adding the seed.
   function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                 input logic [DATA_W-1:0] s,
                                                 input logic inv);
      logic [DATA_W+ADDR_W-1:0] wide;
      logic [DATA_W-1:0]        p;
      wide = {{DATA_W{1'b0}}, a};
      p    = wide[DATA_W-1:0] + s;
      return inv ? ~p : p;
   endfunction

   assign accept     = (state == S_IDLE) && bus.start;
   assign last_addr  = (cnt == ADDR_W'(DEPTH - 1));
   assign last_drain = (cnt == ADDR_W'(LAT - 1));
   assign exp_cur    = pattern(cnt, seed_q, mode_q);
   assign wdata      = exp_cur ^ DATA_W'(inj_q && (cnt == '0));

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) state <= S_IDLE;
      else            state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (bus.start)  state_nx = S_WRITE;
         S_WRITE: if (last_addr)  state_nx = S_READ;
         S_READ:  if (last_addr)  state_nx = S_DRAIN;
         S_DRAIN: if (last_drain) state_nx = S_DONE;
         S_DONE:                  state_nx = S_IDLE;
         default:                 state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      busy  = 1'b0;
      done  = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      unique case (state)
         S_WRITE: begin busy = 1'b1; wr_en = 1'b1; end
         S_READ:  begin busy = 1'b1; rd_en = 1'b1; end
         S_DRAIN: busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         cnt    <= '0;
         mode_q <= 1'b0;
         seed_q <= '0;
         inj_q  <= 1'b0;
      end else begin
         if (accept) begin
            mode_q <= bus.mode;
            seed_q <= bus.seed;
            inj_q  <= bus.inject_err;
         end
         if (state != state_nx) cnt <= '0;
         else if (busy)         cnt <= cnt + 1'b1;
      end
   end

   // Array itself is never reset; contents survive across runs and resets.
   always_ff @(posedge sys_clk) begin
      if (wr_en) mem[cnt] <= wdata;
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n)  ram_q <= '0;
      else if (rd_en)  ram_q <= mem[cnt];
   end

`ifdef RAM_OUT_REG_EN
   logic [DATA_W-1:0] ram_q2;
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n)     ram_q2 <= '0;
      else if (vld_p[0])  ram_q2 <= ram_q;
   end
   assign rd_data = ram_q2;
`else
   assign rd_data = ram_q;
`endif

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         vld_p <= '0;
         for (int i = 0; i < LAT; i++) begin
            exp_p[i] <= '0;
            adr_p[i] <= '0;
         end
      end else begin
         vld_p[0] <= rd_en;
         exp_p[0] <= exp_cur;
         adr_p[0] <= cnt;
`ifdef RAM_OUT_REG_EN
         vld_p[1] <= vld_p[0];
         exp_p[1] <= exp_p[0];
         adr_p[1] <= adr_p[0];
`endif
      end
   end

   assign mismatch = vld_p[LAT-1] && (rd_data != exp_p[LAT-1]);

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         err_cnt   <= '0;
         first_err <= '0;
         pass_q    <= 1'b0;
      end else if (accept) begin
         err_cnt   <= '0;
         first_err <= '0;
         pass_q    <= 1'b0;
      end else begin
         if (mismatch) begin
            if (err_cnt != '1) err_cnt   <= err_cnt + 1'b1;
            if (err_cnt == '0) first_err <= adr_p[LAT-1];
         end
         if (state == S_DONE) pass_q <= (err_cnt == '0);
      end
   end

   // pass must already be valid during the DONE cycle, then is held by pass_q.
   assign bus.pass           = pass_q | ((state == S_DONE) && (err_cnt == '0));
   assign bus.busy           = busy;
   assign bus.done           = done;
   assign bus.err_cnt        = err_cnt;
   assign bus.first_err_addr = first_err;
   assign bus.rd_data        = rd_data;

endmodule

// File: tb/tb_ram_bist_rw.sv
// tb/tb_ram_bist_rw.sv - self-checking bench for ram_bist_rw (honours RAM_OUT_REG_EN)
module tb_ram_bist_rw;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 32;
`ifdef RAM_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam int DONE_K = 2 * DEPTH + LAT;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   ram_bist_rw_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   ram_bist_rw #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int mem_model [DEPTH];

   typedef struct {
      int seed;
      int mode;
      int inj;
      int spot_a;
      int spot_v;
      int exp_pass;
      int exp_err;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int exp_val(input int a, input int s, input int m);
      int p;
      p = (a + s) % 256;
      return (m != 0) ? (255 - p) : p;
   endfunction

   task automatic run(input int s, input int m, input int inj, input int repulse,
                      input bit chain, input int spot_a, input int spot_v,
                      input int exp_pass, input int exp_err);
      int done_k;
      int ndone;
      int a;
      bus.seed       = DATA_W'(s);
      bus.mode       = m[0];
      bus.inject_err = inj[0];
      bus.start      = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         mem_model[i] = exp_val(i, s, m) ^ (((inj != 0) && (i == 0)) ? 1 : 0);
      done_k = -1;
      ndone  = 0;
      for (int k = 1; k <= DONE_K + 1; k++) begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         if (k == 1) chk("busy_after_start", int'(bus.busy), 1);
         if (k >= DEPTH + LAT && k < 2 * DEPTH + LAT) begin
            a = k - DEPTH - LAT;
            chk($sformatf("rd_data[%0d]", a), int'(bus.rd_data), mem_model[a]);
            if (a == spot_a) chk($sformatf("spot[%0d]", a), int'(bus.rd_data), spot_v);
         end
         if (bus.done) begin
            ndone++;
            if (done_k < 0) done_k = k;
         end
         if (k == DONE_K) begin
            chk("pass", int'(bus.pass), exp_pass);
            chk("err_cnt", int'(bus.err_cnt), exp_err);
            chk("first_err_addr", int'(bus.first_err_addr), 0);
            chk("busy_in_done", int'(bus.busy), 0);
         end
         if (k == DONE_K + 1) begin
            chk("busy_after_done", int'(bus.busy), 0);
            chk("pass_held", int'(bus.pass), exp_pass);
         end
         if (repulse == k + 1) begin
            bus.start = 1'b1;
            bus.seed  = ~DATA_W'(s);
         end
         if (chain && k >= DONE_K) bus.start = 1'b1;
      end
      chk("done_cycle", done_k, DONE_K);
      chk("done_pulses", ndone, 1);
   endtask

   initial begin
      int ndone;
      int rs, rm, ri;
      vecs[0] = '{seed: 8'h00, mode: 0, inj: 0, spot_a: 0,  spot_v: 8'h00, exp_pass: 1, exp_err: 0};
      vecs[1] = '{seed: 8'hF0, mode: 0, inj: 0, spot_a: 31, spot_v: 8'h0F, exp_pass: 1, exp_err: 0};
      vecs[2] = '{seed: 8'h10, mode: 1, inj: 0, spot_a: 5,  spot_v: 8'hEA, exp_pass: 1, exp_err: 0};
      vecs[3] = '{seed: 8'h00, mode: 0, inj: 1, spot_a: 0,  spot_v: 8'h01, exp_pass: 0, exp_err: 1};
      vecs[4] = '{seed: 8'h00, mode: 0, inj: 0, spot_a: 31, spot_v: 8'h1F, exp_pass: 1, exp_err: 0};

      bus.start = 1'b0;
      bus.mode = 1'b0;
      bus.seed = '0;
      bus.inject_err = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_pass", int'(bus.pass), 0);
      chk("rst_err_cnt", int'(bus.err_cnt), 0);
      chk("rst_first_err", int'(bus.first_err_addr), 0);
      chk("rst_rd_data", int'(bus.rd_data), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // vecs[3] leaves start high through DONE, so vecs[4] is accepted in the following IDLE.
      for (int i = 0; i < 5; i++)
         run(vecs[i].seed, vecs[i].mode, vecs[i].inj, -1, (i == 3), vecs[i].spot_a,
             vecs[i].spot_v, vecs[i].exp_pass, vecs[i].exp_err);

      run(8'h5A, 0, 0, 10, 1'b0, -1, 0, 1, 0);

      bus.seed = 8'h33;
      bus.mode = 1'b1;
      bus.inject_err = 1'b1;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_done", int'(bus.done), 0);
      chk("abort_pass", int'(bus.pass), 0);
      chk("abort_err_cnt", int'(bus.err_cnt), 0);
      chk("abort_first_err", int'(bus.first_err_addr), 0);
      chk("abort_rd_data", int'(bus.rd_data), 0);
      rst_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < DONE_K + 5; k++) begin
         @(posedge clk);
         #1;
         if (bus.done) ndone++;
      end
      chk("abort_no_done", ndone, 0);
      chk("abort_idle_busy", int'(bus.busy), 0);
      run(8'h77, 0, 0, -1, 1'b0, -1, 0, 1, 0);

      for (int r = 0; r < 4; r++) begin
         rs = int'($urandom_range(0, 255));
         rm = int'($urandom_range(0, 1));
         ri = int'($urandom_range(0, 1));
         run(rs, rm, ri, -1, 1'b0, -1, 0, (ri != 0) ? 0 : 1, ri);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
